// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - N-channel W-bit registered multiplexer with auto-scan
//
// Forwards one of N parallel channels to a single registered output. In
// manual mode the channel comes from sel. In scan mode a dwell counter walks
// the channels 0..N-1 round-robin, holding each for dwell+1 cycles.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   in_bus - N*W packed channels, channel k at in_bus[k*W +: W]
//   sel    - manual channel select
//   en     - output enable (0 forces IDLE)
//   mode   - 0 = manual, 1 = scan
//   dwell  - scan hold length minus one
//   y      - registered selected data
//   ch     - index of the channel currently on y
//   valid  - y carries live channel data
//   wrap   - one-cycle pulse when the scan goes from N-1 back to 0
module mux_scan_n #(
  parameter int N       = 4,
  parameter int W       = 1,
  parameter int DWELL_W = 8,
  localparam int CW     = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*W-1:0]     in_bus,
  input  logic [CW-1:0]      sel,
  input  logic               en,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [W-1:0]       y,
  output logic [CW-1:0]      ch,
  output logic               valid,
  output logic               wrap
);

  localparam logic [CW:0]   NUM_CH = (CW + 1)'(N);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  state_t             state, state_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx, cnt_cur;
  logic [CW-1:0]      ch_nx;
  logic [W-1:0]       y_nx;
  logic               valid_nx, wrap_nx;

  // A scan entered from IDLE or MANUAL always begins with a fresh dwell, so
  // the first channel gets its full dwell+1 cycles regardless of stale cnt.
  assign cnt_cur = (state == SCAN) ? cnt : '0;

  always_comb begin
    state_nx = IDLE;
    ch_nx    = ch;
    y_nx     = '0;
    valid_nx = 1'b0;
    wrap_nx  = 1'b0;
    cnt_nx   = '0;

    if (en) begin
      state_nx = mode ? SCAN : MANUAL;
    end

    // Outputs follow the state being entered, giving one clock of latency
    // from en/mode/sel to y/ch/valid with no bubble on mode changes.
    unique case (state_nx)
      MANUAL: begin
        // sel beyond the last channel only exists when N is not a power of
        // two; it blanks the output and leaves ch where it was.
        if ({1'b0, sel} < NUM_CH) begin
          ch_nx    = sel;
          y_nx     = in_bus[sel*W +: W];
          valid_nx = 1'b1;
        end
      end
      SCAN: begin
        valid_nx = 1'b1;
        // >= so that lowering dwell below the running count advances at once.
        if (cnt_cur >= dwell) begin
          ch_nx   = (ch == LAST) ? '0 : ch + 1'b1;
          wrap_nx = (ch == LAST);
        end else begin
          ch_nx  = ch;
          cnt_nx = cnt_cur + 1'b1;
        end
        y_nx = in_bus[ch_nx*W +: W];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ch    <= '0;
      y     <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ch    <= ch_nx;
      y     <= y_nx;
      valid <= valid_nx;
      wrap  <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - self-checking bench for mux_scan_n (N=4 and N=3)
module tb_mux_scan_n;

  logic        clk;
  logic        rst;

  logic [31:0] in_bus4;
  logic [1:0]  sel4;
  logic        en4, mode4;
  logic [7:0]  dwell4;
  logic [7:0]  y4;
  logic [1:0]  ch4;
  logic        valid4, wrap4;

  logic [23:0] in_bus3;
  logic [1:0]  sel3;
  logic        en3, mode3;
  logic [7:0]  dwell3;
  logic [7:0]  y3;
  logic [1:0]  ch3;
  logic        valid3, wrap3;

  int checks   = 0;
  int failures = 0;

  // Expected {y, ch, valid, wrap} pushed when stimulus is applied.
  logic [11:0] exp_q[$];

  mux_scan_n #(.N(4), .W(8), .DWELL_W(8)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .in_bus(in_bus4),
    .sel   (sel4),
    .en    (en4),
    .mode  (mode4),
    .dwell (dwell4),
    .y     (y4),
    .ch    (ch4),
    .valid (valid4),
    .wrap  (wrap4)
  );

  mux_scan_n #(.N(3), .W(8), .DWELL_W(8)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .in_bus(in_bus3),
    .sel   (sel3),
    .en    (en3),
    .mode  (mode3),
    .dwell (dwell3),
    .y     (y3),
    .ch    (ch3),
    .valid (valid3),
    .wrap  (wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dat(input int k);
    case (k)
      0:       return 8'hA1;
      1:       return 8'hB2;
      2:       return 8'hC3;
      default: return 8'hD4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd2;
    exp_q.push_back({8'hC3, 2'd2, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({y4, ch4, valid4, wrap4} !== e) begin
      failures++;
      $display("FAIL reset_pre: got %h expected %h", {y4, ch4, valid4, wrap4}, e);
    end
    #3 rst = 1'b1;
    exp_q.push_back(12'h000);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({y4, ch4, valid4, wrap4} !== e) begin
      failures++;
      $display("FAIL reset_async: got %h expected %h", {y4, ch4, valid4, wrap4}, e);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(12'h000);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({y4, ch4, valid4, wrap4} !== e) begin
        failures++;
        $display("FAIL reset_hold_%0d: got %h expected %h", i, {y4, ch4, valid4, wrap4}, e);
      end
    end
    rst = 1'b0;
    exp_q.push_back({8'hC3, 2'd2, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({y4, ch4, valid4, wrap4} !== e) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", {y4, ch4, valid4, wrap4}, e);
    end
  endtask

  task automatic test_manual();
    logic [11:0] e;
    en4 = 1'b1; mode4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      exp_q.push_back({dat(i), 2'(i), 1'b1, 1'b0});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({y4, ch4, valid4, wrap4} !== e) begin
        failures++;
        $display("FAIL manual_sel%0d: got %h expected %h", i, {y4, ch4, valid4, wrap4}, e);
      end
    end
    sel4 = 2'd2;
    in_bus4[23:16] = 8'h5E;
    exp_q.push_back({8'h5E, 2'd2, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({y4, ch4, valid4, wrap4} !== e) begin
      failures++;
      $display("FAIL manual_data_change: got %h expected %h", {y4, ch4, valid4, wrap4}, e);
    end
    in_bus4[23:16] = 8'hC3;
  endtask

  task automatic test_scan();
    logic [11:0] e;
    int seq[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    do_reset();
    en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd0; dwell4 = 8'd2;
    for (int i = 0; i < 13; i++) begin
      if (i == 1) mode4 = 1'b1;
      exp_q.push_back({dat(seq[i]), 2'(seq[i]), 1'b1, (i == 12)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({y4, ch4, valid4, wrap4} !== e) begin
        failures++;
        $display("FAIL scan_step%0d: got %h expected %h", i, {y4, ch4, valid4, wrap4}, e);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [11:0] e;
    logic [11:0] tail[7];
    int seq[8] = '{0, 0, 0, 1, 1, 1, 2, 2};
    do_reset();
    en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd0; dwell4 = 8'd2;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) mode4 = 1'b1;
      exp_q.push_back({dat(seq[i]), 2'(seq[i]), 1'b1, 1'b0});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({y4, ch4, valid4, wrap4} !== e) begin
        failures++;
        $display("FAIL drop_pre%0d: got %h expected %h", i, {y4, ch4, valid4, wrap4}, e);
      end
    end
    // en off at ch=2 cnt=1, back on in scan, then off again exactly when
    // the scan would have wrapped from 3 to 0.
    tail[0] = {8'h00, 2'd2, 1'b0, 1'b0};
    tail[1] = {8'hC3, 2'd2, 1'b1, 1'b0};
    tail[2] = {8'hC3, 2'd2, 1'b1, 1'b0};
    tail[3] = {8'hD4, 2'd3, 1'b1, 1'b0};
    tail[4] = {8'hD4, 2'd3, 1'b1, 1'b0};
    tail[5] = {8'hD4, 2'd3, 1'b1, 1'b0};
    tail[6] = {8'h00, 2'd3, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      en4 = (i != 0 && i != 6);
      exp_q.push_back(tail[i]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({y4, ch4, valid4, wrap4} !== e) begin
        failures++;
        $display("FAIL drop_post%0d: got %h expected %h", i, {y4, ch4, valid4, wrap4}, e);
      end
    end
  endtask

  task automatic test_n3();
    logic [11:0] e;
    int seq[7] = '{0, 1, 2, 0, 1, 2, 0};
    en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; dwell3 = 8'd0;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) mode3 = 1'b1;
      exp_q.push_back({dat(seq[i]), 2'(seq[i]), 1'b1, (i == 3 || i == 6)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({y3, ch3, valid3, wrap3} !== e) begin
        failures++;
        $display("FAIL n3_scan%0d: got %h expected %h", i, {y3, ch3, valid3, wrap3}, e);
      end
    end
    mode3 = 1'b0; sel3 = 2'd1;
    exp_q.push_back({8'hB2, 2'd1, 1'b1, 1'b0});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({y3, ch3, valid3, wrap3} !== e) begin
      failures++;
      $display("FAIL n3_manual1: got %h expected %h", {y3, ch3, valid3, wrap3}, e);
    end
    sel3 = 2'd3;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({8'h00, 2'd1, 1'b0, 1'b0});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({y3, ch3, valid3, wrap3} !== e) begin
        failures++;
        $display("FAIL n3_sel_oob%0d: got %h expected %h", i, {y3, ch3, valid3, wrap3}, e);
      end
    end
    en3 = 1'b0;
  endtask

  task automatic test_live_dwell();
    logic [11:0] e;
    int seq[12] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset();
    en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd0; dwell4 = 8'd5;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) mode4 = 1'b1;
      if (i == 5) dwell4 = 8'd1;
      exp_q.push_back({dat(seq[i]), 2'(seq[i]), 1'b1, (i == 11)});
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({y4, ch4, valid4, wrap4} !== e) begin
        failures++;
        $display("FAIL live_dwell%0d: got %h expected %h", i, {y4, ch4, valid4, wrap4}, e);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    in_bus4 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    in_bus3 = {8'hC3, 8'hB2, 8'hA1};
    sel4 = '0; en4 = 1'b0; mode4 = 1'b0; dwell4 = '0;
    sel3 = '0; en3 = 1'b0; mode3 = 1'b0; dwell3 = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_manual();
    test_scan();
    test_enable_drop();
    en4 = 1'b0;
    test_n3();
    test_live_dwell();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
